// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: synchronous instruction memory with a request/response
// handshake, WAIT_CYCLES extra wait states, bad-address flagging, flush for
// redirects and a run-time program load port.
// Optional: define INST_MEM_PREFETCH_EN to add a one-entry next-sequential
// buffer that serves a hit on the following word with latency 1.
module inst_fetch_mem #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    // Misaligned, or word index beyond DEPTH (any byte-address bit above the index set).
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a[ADDR_W-1:IDX_W+2] != '0);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;
    logic              cap_err_q, cap_err_d;

    logic              accept, req_bad, load_ok;
    logic              pf_hit, pf_rerr;
    logic [DATA_W-1:0] pf_rdata;

    assign accept  = (state_q == S_IDLE) && req_valid && !flush;
    assign req_bad = addr_bad(req_addr);
    assign load_ok = load_en && !addr_bad(load_addr);

`ifdef INST_MEM_PREFETCH_EN
    logic              pf_valid_q, pf_valid_d;
    logic [ADDR_W-1:0] pf_tag_q, pf_tag_d;
    logic [DATA_W-1:0] pf_data_q, pf_data_d;
    logic              pf_err_q, pf_err_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_bad;

    assign pf_hit   = pf_valid_q && (req_addr == pf_tag_q);
    assign pf_rdata = pf_data_q;
    assign pf_rerr  = pf_err_q;
    assign nxt_addr = base_q + ADDR_W'(4);
    assign nxt_bad  = addr_bad(nxt_addr);

    // Fill the buffer with the following word as a good response retires; drop it on flush or a load to its word.
    always_comb begin
        pf_valid_d = pf_valid_q;
        pf_tag_d   = pf_tag_q;
        pf_data_d  = pf_data_q;
        pf_err_d   = pf_err_q;
        base_d     = accept ? req_addr : base_q;
        if (state_q == S_RESP && !flush && !cap_err_q) begin
            pf_valid_d = 1'b1;
            pf_tag_d   = nxt_addr;
            pf_err_d   = nxt_bad;
            pf_data_d  = nxt_bad ? '0 : mem[nxt_addr[IDX_W+1:2]];
        end
        if (flush) pf_valid_d = 1'b0;
        if (load_ok && load_addr == pf_tag_d) pf_valid_d = 1'b0;
    end

    // Prefetch buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_data_q  <= '0;
            pf_err_q   <= 1'b0;
            base_q     <= '0;
        end else begin
            pf_valid_q <= pf_valid_d;
            pf_tag_q   <= pf_tag_d;
            pf_data_q  <= pf_data_d;
            pf_err_q   <= pf_err_d;
            base_q     <= base_d;
        end
    end
`else
    assign pf_hit   = 1'b0;
    assign pf_rdata = '0;
    assign pf_rerr  = 1'b0;
`endif

    // FSM next state: accept in IDLE, count WAIT_CYCLES+1 wait cycles, one-cycle RESP.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_data_d = cap_data_q;
        cap_err_d  = cap_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (pf_hit) begin
                        cap_data_d = pf_rdata;
                        cap_err_d  = pf_rerr;
                        state_d    = S_RESP;
                    end else begin
                        // Read happens against pre-edge contents, so a same-edge load returns the old word.
                        cap_data_d = req_bad ? '0 : mem[req_addr[IDX_W+1:2]];
                        cap_err_d  = req_bad;
                        cnt_d      = 4'(WAIT_CYCLES);
                        state_d    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush)              state_d = S_IDLE;
                else if (cnt_q == 4'd0) state_d = S_RESP;
                else                    cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if (state_d == S_RESP && state_q != S_RESP) begin
            resp_data_d = cap_data_d;
            resp_err_d  = cap_err_d;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            cap_data_q   <= '0;
            cap_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            cap_data_q   <= cap_data_d;
            cap_err_q    <= cap_err_d;
        end
    end

    // Program load; contents survive reset.
    always_ff @(posedge clk) begin
        if (load_ok) mem[load_addr[IDX_W+1:2]] <= load_data;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q && !flush;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_inst_fetch_mem.sv
// Bench for inst_fetch_mem (DEPTH=16, WAIT_CYCLES=2) against a word-array
// reference model with a last-response next-word prefetch model.
module tb_inst_fetch_mem;
    localparam int W = 2;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0] mm [D];
    bit          pfv = 1'b0;
    logic [31:0] pfa = '0;

    inst_fetch_mem #(.DATA_W(32), .DEPTH(D), .ADDR_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_err(resp_err), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    function automatic bit m_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= D);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_load(input logic [31:0] a, input logic [31:0] d);
        if (!m_bad(a)) begin
            mm[a / 4] = d;
            if (pfv && a == pfa) pfv = 1'b0;
        end
    endtask

    task automatic check_idle(input string nm);
        vec_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s: resp_valid=%b req_ready=%b, expected 0/1", nm, resp_valid, req_ready);
        end
    endtask

    // Loads while idle; called at a negedge, returns at a negedge.
    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
        model_load(a, d);
    endtask

    // One fetch with optional same-edge load; checks ready, latency, data, err.
    task automatic fetch(input logic [31:0] a, input bit ld, input logic [31:0] la,
                         input logic [31:0] ldat, input string nm);
        logic [31:0] ed;
        bit          ee;
        int          lat;
        ee  = m_bad(a);
        ed  = ee ? 32'h0 : mm[a / 4];
`ifdef INST_MEM_PREFETCH_EN
        lat = (pfv && a == pfa) ? 1 : W + 2;
`else
        lat = W + 2;
`endif
        vec_cnt++;
        if (req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s accept: req_ready=%b expected 1", nm, req_ready);
        end
        req_valid = 1'b1; req_addr = a;
        load_en = ld; load_addr = la; load_data = ldat;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; load_en = 1'b0;
        if (ld) model_load(la, ldat);
        for (int k = 1; k <= lat + 1; k++) begin
            vec_cnt++;
            if (k == lat) begin
                if (resp_valid !== 1'b1 || resp_data !== ed || resp_err !== ee || req_ready !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL %s resp@%0d: valid=%b data=%h err=%b rdy=%b, expected 1 %h %b 0",
                             nm, k, resp_valid, resp_data, resp_err, req_ready, ed, ee);
                end
            end else if (resp_valid !== 1'b0 || req_ready !== (k > lat)) begin
                err_cnt++;
                $display("FAIL %s cyc%0d: valid=%b rdy=%b, expected 0 %b", nm, k, resp_valid, req_ready, k > lat);
            end
            if (k <= lat) tick();
        end
        if (!ee) begin
            pfv = 1'b1;
            pfa = a + 32'd4;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_held: rdy=%b valid=%b data=%h err=%b, expected 1 0 0 0", req_ready, resp_valid, resp_data, resp_err);
        end
        reset = 1'b0;
        tick();
        vec_cnt++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_released: rdy=%b valid=%b data=%h err=%b, expected 1 0 0 0", req_ready, resp_valid, resp_data, resp_err);
        end
        for (int i = 0; i < D; i++) do_load(32'(i * 4), $urandom);
    endtask

    task automatic test_latency();
        do_load(32'h10, 32'h8C260000);
        fetch(32'h10, 1'b0, 0, 0, "lat_0x10");
        fetch(32'h00, 1'b0, 0, 0, "lat_0x00");
        fetch(32'h3C, 1'b0, 0, 0, "lat_last");
    endtask

    task automatic test_err();
        fetch(32'h12, 1'b0, 0, 0, "err_misalign");
        fetch(32'h40, 1'b0, 0, 0, "err_range");
        fetch(32'hFFFF_FFFC, 1'b0, 0, 0, "err_high");
    endtask

    task automatic test_flush();
        // Flush during WAIT.
        req_valid = 1'b1; req_addr = 32'h00;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; pfv = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            check_idle("flush_wait");
            tick();
        end
        fetch(32'h04, 1'b0, 0, 0, "after_flush");
        // Flush in the RESP cycle kills the pulse immediately.
        req_valid = 1'b1; req_addr = 32'h08;
        tick();
        req_valid = 1'b0;
        repeat (W + 1) tick();
        flush = 1'b1;
        #1;
        vec_cnt++;
        if (resp_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_resp_kill: resp_valid=%b expected 0", resp_valid);
        end
        @(negedge clk);
        flush = 1'b0; pfv = 1'b0;
        check_idle("flush_resp_after");
        // Flush in IDLE blocks acceptance.
        req_valid = 1'b1; req_addr = 32'h0C; flush = 1'b1;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            check_idle("flush_idle");
            tick();
        end
    endtask

    task automatic test_rbw();
        fetch(32'h08, 1'b1, 32'h08, 32'hDEADBEEF, "rbw_old");
        fetch(32'h08, 1'b0, 0, 0, "rbw_new");
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 32'h0C;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check_idle("reset_mid");
        @(negedge clk);
        reset = 1'b0; pfv = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            check_idle("reset_mid_quiet");
            tick();
        end
    endtask

    task automatic test_prefetch();
        fetch(32'h20, 1'b0, 0, 0, "pf_first");
        fetch(32'h24, 1'b0, 0, 0, "pf_hit");
        fetch(32'h20, 1'b0, 0, 0, "pf_again");
        do_load(32'h24, 32'hCAFE_0024);
        fetch(32'h24, 1'b0, 0, 0, "pf_invalidated");
        fetch(32'h3C, 1'b0, 0, 0, "pf_last");
        fetch(32'h40, 1'b0, 0, 0, "pf_err_tag");
    endtask

    task automatic test_random();
        logic [31:0] a, la;
        int          r;
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 30 && a < 32'h3C)  a = a + 32'd4;
            else if (r < 80)           a = 32'($urandom_range(0, D - 1) * 4);
            else if (r < 90)           a = 32'($urandom_range(0, D * 4 - 1)) | 32'h1;
            else                       a = 32'($urandom_range(D, 4 * D) * 4);
            la = 32'($urandom_range(0, D + 1) * 4);
            if ($urandom_range(0, 3) == 0) la = la | 32'h2;
            if ($urandom_range(0, 4) == 0) do_load(la, $urandom);
            fetch(a, $urandom_range(0, 2) == 0, la, $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_err();
        test_flush();
        test_rbw();
        test_reset_mid();
        test_prefetch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
